down_timer: RTL and testbench
=============================

// Module: down_timer
//
// PURPOSE
//   Loadable down-counting timer: the count-to-zero counterpart of the free-running up counter.
//   A value is written in through a valid/ready load port. A start request then decrements it
//   once per clock and raises a one-cycle expiry pulse when it reaches zero.
//   Used as the event/timeout generator beside the up counter in the counter subsystem.
//
// PARAMETERS
//   WIDTH   32   count, load_value and reload register width in bits
//
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous reset, active-low
//   load_valid   in   1      load_value is valid this cycle
//   load_ready   out  1      timer accepts a load (high only in IDLE)
//   load_value   in   WIDTH  new start value
//   start        in   1      one-cycle request: begin or resume counting
//   stop         in   1      one-cycle request: pause counting and keep count
//   count        out  WIDTH  current remaining count (registered)
//   busy         out  1      high while state == RUN
//   expired      out  1      one-cycle pulse; count has just reached terminal value
//
// BEHAVIOUR
//   - Reset (rst_n low, async): state=IDLE, count=0, reload=0, busy=0, expired=0, load_ready=1.
//     Reset asserted mid-RUN clears everything immediately. Counting restarts only after a new start.
//   - States: IDLE (counter held), RUN (decrementing). The state register is 1 bit.
//   - load_ready = (state==IDLE). It is combinational from the state only, never from load_valid.
//   - Load: when load_valid && load_ready at edge k, count=load_value and reload=load_value after edge k.
//     In RUN, load_valid is ignored and nothing is latched.
//   - IDLE + start, with count!=0 at edge k: state=RUN after edge k. The first decrement happens at edge k+1.
//   - IDLE + start, with count==0: the timer stays in IDLE and expired pulses after edge k (zero-length timeout).
//   - Load and start in the same cycle: the load wins and start is ignored.
//   - RUN: at each edge, count=count-1. busy=1.
//   - Terminal: in RUN with count==1, the edge sets count=0, state=IDLE, expired=1 for exactly one cycle.
//   - stop in RUN: state=IDLE after the edge, count holds its value and is not decremented. A later start resumes.
//   - start and stop asserted together: stop wins in RUN. In IDLE, both are ignored.
//   - start while already in RUN has no effect. stop while in IDLE has no effect.
//   - Arithmetic is modulo 2^WIDTH, but count never decrements below 0 because RUN is left at the 1->0 step.
//     The all-ones value (2^WIDTH-1) is a legal load.
//   - expired is registered and is never high for two consecutive cycles, except under auto-reload with reload==1.
//
// CONFIGURATION
//   DOWN_TIMER_AUTORELOAD_EN
//     defined:
//       - At the terminal step (RUN, count==1), with reload!=0: count=reload, state stays RUN,
//         expired pulses once. This gives a periodic expiry every reload cycles.
//       - If reload==0, the timer behaves as if the macro were undefined.
//       - stop still pauses.
//     undefined:
//       - One-shot only. The timer returns to IDLE at terminal, and the reload register is still
//         written but unused.
//
// TESTING
//   1. Reset check: rst_n=0 -> count=0, busy=0, expired=0, load_ready=1.
//      Release rst_n, no stimulus for 5 cycles -> outputs unchanged.
//   2. One-shot: load 5, then start.
//      -> count reads 4,3,2,1,0 on the next 5 edges.
//      -> expired is high only in the cycle count==0, and busy drops in that same cycle.
//   3. Pause/resume: load 10, start, stop when count==6.
//      -> count holds 6 for 4 idle cycles, then start -> 5,4..0, expired once.
//   4. Boundary inputs:
//      - load 0 then start -> expired pulse next cycle, busy never rises.
//      - load_valid during RUN -> load_ready=0, count unaffected.
//      - start+stop together in RUN -> pause.
//   5. Async reset mid-run: load 100, start, drop rst_n when count==60, between edges.
//      -> count=0 immediately, busy=0. No expired pulse after release.
//   6. With DOWN_TIMER_AUTORELOAD_EN: load 3, start -> expired every 3 cycles.
//      Count sequence is 2,1,3,2,1,3...; busy stays 1 until stop.
//      Without the macro, the same stimulus gives a single expiry.

Source files
------------

// File: rtl/down_timer.sv
// Loadable down-counter with a one-cycle expiry pulse; loads only in IDLE, load_ready is a function of state alone.
// Count/expired are registered (1-cycle). Optional periodic reload under `define DOWN_TIMER_AUTORELOAD_EN.
module down_timer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             expired
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_expired;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             w_expired_nxt;
   logic             w_terminal;
   logic             w_do_reload;

   assign w_terminal = (r_count == WIDTH'(1));

`ifdef DOWN_TIMER_AUTORELOAD_EN
   assign w_do_reload = (r_reload != '0);
`else
   assign w_do_reload = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_reload  <= '0;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_reload  <= w_reload_nxt;
         r_expired <= w_expired_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_reload_nxt  = r_reload;
      w_expired_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A load shadows any start in the same cycle; start+stop together is a no-op here.
            if (load_valid) begin
               w_count_nxt  = load_value;
               w_reload_nxt = load_value;
            end else if (start && !stop) begin
               if (r_count != '0) begin
                  w_state_nxt = S_RUN;
               end else begin
                  w_expired_nxt = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
            end else if (w_terminal) begin
               w_expired_nxt = 1'b1;
               if (w_do_reload) begin
                  w_count_nxt = r_reload;
               end else begin
                  w_count_nxt = '0;
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_count_nxt = r_count - WIDTH'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign load_ready = (r_state == S_IDLE);
   assign busy       = (r_state == S_RUN);
   assign count      = r_count;
   assign expired    = r_expired;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer; outputs sampled 1ns after each rising edge.
module tb_down_timer;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic             stop;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             expired;

   int n_checks = 0;
   int n_errors = 0;

   down_timer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .start      (start),
      .stop       (stop),
      .count      (count),
      .busy       (busy),
      .expired    (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_value = '0;
      start      = 1'b0;
      stop       = 1'b0;

      // Reset state
      #3;
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_expired", expired, 0);
      chk("rst_load_ready", load_ready, 1);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_count", count, 0);
         chk("idle_busy", busy, 0);
         chk("idle_expired", expired, 0);
      end
      chk("idle_load_ready", load_ready, 1);

      // One-shot from 5
      load_valid = 1'b1; load_value = 5;
      tick();
      chk("load5_count", count, 5);
      load_valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("os_busy_start", busy, 1);
      chk("os_count_start", count, 5);
      chk("os_load_ready", load_ready, 0);
      for (int e = 4; e >= 0; e--) begin
         tick();
         chk("os_count", count, e);
         chk("os_expired", expired, (e == 0) ? 1 : 0);
         chk("os_busy", busy, (e != 0) ? 1 : 0);
      end
      tick();
      chk("os_expired_after", expired, 0);
      chk("os_count_after", count, 0);

      // Pause at 6, resume
      load_valid = 1'b1; load_value = 10;
      tick();
      load_valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 9; e >= 6; e--) begin
         tick();
         chk("pr_count_dn", count, e);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("pr_busy_stop", busy, 0);
      chk("pr_count_stop", count, 6);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("pr_hold_count", count, 6);
         chk("pr_hold_busy", busy, 0);
         chk("pr_hold_expired", expired, 0);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("pr_resume_busy", busy, 1);
      chk("pr_resume_count", count, 6);
      for (int e = 5; e >= 0; e--) begin
         tick();
         chk("pr_count_res", count, e);
         chk("pr_expired_res", expired, (e == 0) ? 1 : 0);
      end
      tick();
      chk("pr_expired_once", expired, 0);

      // Zero-length timeout
      load_valid = 1'b1; load_value = 0;
      tick();
      load_valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("z_expired", expired, 1);
      chk("z_busy", busy, 0);
      chk("z_load_ready", load_ready, 1);
      tick();
      chk("z_expired_end", expired, 0);
      chk("z_busy_end", busy, 0);

      // Load ignored in RUN
      load_valid = 1'b1; load_value = 20;
      tick();
      load_valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      load_valid = 1'b1; load_value = 7;
      #1;
      chk("lr_ready_run", load_ready, 0);
      tick();
      chk("lr_count1", count, 19);
      tick();
      chk("lr_count2", count, 18);
      load_valid = 1'b0;

      // start+stop together: pause in RUN, ignored in IDLE
      start = 1'b1; stop = 1'b1;
      tick();
      chk("ss_run_busy", busy, 0);
      chk("ss_run_count", count, 18);
      tick();
      start = 1'b0; stop = 1'b0;
      chk("ss_idle_busy", busy, 0);
      chk("ss_idle_count", count, 18);
      chk("ss_idle_expired", expired, 0);

      // Async reset mid-run at count 60
      load_valid = 1'b1; load_value = 100;
      tick();
      load_valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (40) tick();
      chk("ar_count_pre", count, 60);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_count", count, 0);
      chk("ar_busy", busy, 0);
      chk("ar_load_ready", load_ready, 1);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ar_post_expired", expired, 0);
         chk("ar_post_busy", busy, 0);
         chk("ar_post_count", count, 0);
      end

      // Terminal handling from 3: periodic with auto-reload, single shot without
      load_valid = 1'b1; load_value = 3;
      tick();
      load_valid = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t3_busy_start", busy, 1);
`ifdef DOWN_TIMER_AUTORELOAD_EN
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t3_count", count, 2 - (i % 3) + ((i % 3 == 2) ? 3 : 0));
         chk("t3_expired", expired, (i % 3 == 2) ? 1 : 0);
         chk("t3_busy", busy, 1);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t3_stop_busy", busy, 0);
      chk("t3_stop_count", count, 3);
`else
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t3_count", count, (i < 3) ? (2 - i) : 0);
         chk("t3_expired", expired, (i == 2) ? 1 : 0);
         chk("t3_busy", busy, (i < 2) ? 1 : 0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
